// File: rtl/d_mem_port_arb.sv
// -----------------------------------------------------------------------------
// d_mem_port_arb
//
// Round-robin arbiter sharing one synchronous-read data-memory port (1-cycle
// read latency) among NUM_REQ requesters. The memory-side port is driven
// combinationally from the current winner. Registered read data is routed
// back to the requester that issued the read. A requester may take an
// exclusive lock for read-modify-write sequences. The lock is force-released
// after LOCK_MAX cycles.
//
// Ports
//   clock, rst_n      core clock, asynchronous active-low reset
//   req_valid/wr/lock per-requester request, write select, lock request
//   req_addr          NUM_REQ x AW word addresses, requester i at [i*AW +: AW]
//   req_byteen        NUM_REQ x 4 byte enables (writes only)
//   req_data          NUM_REQ x 32 write data
//   req_ready         one-hot grant; an access is accepted on valid & ready
//   rsp_valid         one-cycle pulse: read data on rsp_data belongs to i
//   rsp_data          shared read-data bus, qualified by rsp_valid
//   lock_expired      one-cycle pulse on a forced lock release
//   mem_*             memory port (address, byte enables, write data,
//                     read/write enables, read data mem_q)
// -----------------------------------------------------------------------------
module d_mem_port_arb #(
  parameter int NUM_REQ  = 4,
  parameter int AW       = 12,
  parameter int LOCK_MAX = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]  req_byteen,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  lock_expired,
  output logic [AW-1:0]         mem_address,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            rd_pend_q;
  logic [IW-1:0]   rd_id_q;

  logic            rr_found;
  logic [IW-1:0]   rr_winner;
  logic [IW:0]     scan_idx;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;
  logic            expire;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == IW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    rr_found  = 1'b0;
    rr_winner = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (scan_idx >= (IW+1)'(NUM_REQ)) scan_idx = scan_idx - (IW+1)'(NUM_REQ);
      if (!rr_found && req_valid[scan_idx[IW-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = scan_idx[IW-1:0];
      end
    end
  end

  // Grant decision. While locked only the owner may win. The expiry cycle
  // grants nobody so the forced release is clean.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_winner;
    expire    = 1'b0;
    case (state_q)
      S_IDLE:   grant_vld = rr_found;
      S_LOCKED: begin
        if (lock_cnt_q == CW'(LOCK_MAX)) begin
          expire = 1'b1;
        end else begin
          grant_id  = owner_q;
          grant_vld = req_valid[owner_q];
        end
      end
      default: ;
    endcase
    // Keep the port and grants quiet while reset is held.
    grant_vld = grant_vld & rst_n;
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= grant_vld & ~req_wr[grant_id];
      rd_id_q    <= grant_id;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          rr_ptr_d = next_id(grant_id);
          if (req_lock[grant_id]) begin
            state_d    = S_LOCKED;
            owner_d    = grant_id;
            lock_cnt_d = CW'(1);
          end
        end
      end
      S_LOCKED: begin
        if (expire) begin
          state_d    = S_IDLE;
          rr_ptr_d   = next_id(owner_q);
          lock_cnt_d = '0;
        end else if (!req_lock[owner_q]) begin
          // The owner's access in this cycle, if any, is still granted.
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: memory port from the winner, read return from the pending slot.
  always_comb begin
    req_ready    = '0;
    mem_address  = '0;
    mem_byteena  = '0;
    mem_data     = '0;
    mem_rden     = 1'b0;
    mem_wren     = 1'b0;
    rsp_valid    = '0;
    rsp_data     = '0;
    lock_expired = expire;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
      mem_address         = req_addr[grant_id*AW +: AW];
      mem_data            = req_data[grant_id*32 +: 32];
      mem_wren            = req_wr[grant_id];
      mem_rden            = ~req_wr[grant_id];
      mem_byteena         = req_wr[grant_id] ? req_byteen[grant_id*4 +: 4] : 4'h0;
    end
    if (rd_pend_q) begin
      rsp_valid[rd_id_q] = 1'b1;
      rsp_data           = mem_q;
    end
  end

endmodule
